awb_gain_apply: RTL and testbench
=================================

Name: awb_gain_apply

Overview:
Applies per-channel white-balance gains to the tagged Bayer pixel stream. The gains are the R/G/B gains produced by the frame-statistics gain calculator. Sits directly downstream of that calculator, on the same 16-bit pixel bus: bits [15:4] are the 12-bit pixel, bits [3:0] are the colour tags. Gains are double-buffered so that a whole frame is processed with one consistent gain set.

Parameters:
GAIN_FRAC, 5, fractional bits of the 8-bit unsigned gain (32 = 1.0x, max 7.97x)
PIX_MAX, 12'hFFF, saturation ceiling for the output pixel

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous active-low reset
Din  input  16  [15:4] pixel, [3:0] tags: bit2=R, bit3/bit0=G, bit1=B
data_en  input  1  Din qualifier
sof  input  1  start of frame, qualified by data_en, marks first pixel
eof  input  1  end of frame, qualified by data_en, marks last pixel
rGain  input  8  red gain from the gain calculator
gGain  input  8  green gain
bGain  input  8  blue gain
gain_upd  input  1  one-cycle pulse: live gains are valid and new
bypass  input  1  force unity gain; sampled per pixel
Dout  output  16  [15:4] corrected pixel, [3:0] tags passed through unchanged
dout_en  output  1  Dout qualifier
sof_o  output  1  sof delayed and aligned to Dout
eof_o  output  1  eof delayed and aligned to Dout
in_frame  output  1  FSM is in ACTIVE
err_cnt  output  16  saturating count of tag and framing errors

Behaviour:
- Reset (asynchronous, rst_n low):
  - All outputs are 0; FSM goes to IDLE.
  - The shadow gains (active set) are all loaded with 1<<GAIN_FRAC; the pending flag is cleared.
- Gain double-buffer:
  - gain_upd captures rGain/gGain/bGain into a pending set and sets the pending flag.
  - On an accepted sof (data_en & sof), if pending is set: pending moves to shadow and the flag clears. The loaded shadow applies to the sof pixel itself.
  - gain_upd in the same cycle as sof: the new values go to pending only and take effect at the next sof.
  - gain_upd again before sof: the pending set is overwritten (last one wins).
- FSM (advances only on data_en):
  - IDLE: sof goes to ACTIVE. Pixels without sof still pass through with unity gain, dout_en asserted. eof is ignored and adds 1 to err_cnt.
  - ACTIVE: eof goes to IDLE after that pixel. sof in ACTIVE is a restart: stay ACTIVE, shadow reload rule applied, err_cnt +1.
  - sof and eof on the same pixel: treated as a one-pixel frame, ends in IDLE.
- Gain select per pixel, evaluated in this order:
  - bypass set, or not in a frame (IDLE and not sof): unity gain.
  - Tag legal (exactly one of bit2, bit1, or bit3|bit0): R, B or G shadow gain respectively. bit3 and bit0 set together counts as G (legal).
  - Tag illegal (4'b0000, or R/B combined with any other bit): unity gain, err_cnt +1.
  - err_cnt saturates at 16'hFFFF.
- Datapath, fixed 2-cycle latency, no backpressure:
  - Stage 1 registers the 20-bit product pixel*gain, plus tags and sof/eof/en.
  - Stage 2: (product + (1<<(GAIN_FRAC-1))) >> GAIN_FRAC, saturated to PIX_MAX, registered onto Dout[15:4].
  - Dout[3:0] is the registered input tag.
- Output timing:
  - dout_en, sof_o and eof_o equal data_en, sof and eof delayed exactly 2 cycles.
  - When dout_en=0, Dout holds its last value.
- Reset mid-frame: the pipeline is flushed (dout_en=0). Gains return to unity and pending is lost.

Decomposition:
- Shared ISP package: tag bit positions (TAG_R=2, TAG_B=1, TAG_GR=0, TAG_GB=3), GAIN_FRAC default, unity-gain constant, PIXEL_W=12.
- One sub-module, awb_mul_sat: the 2-stage multiply/round/saturate pipe. It is instanced once, with the gain muxed in front.

Test Plan:
- Reset, then sof with Din={12'h800,4'b0100} and no gain_upd -> 2 cycles later Dout={12'h800,4'b0100}, sof_o=1, in_frame=1.
- gain_upd with rGain=64, then sof with R pixel 12'h900 -> Dout[15:4]=12'hFFF (saturated). Then G pixel 12'h100 with gGain=32 -> 12'h100.
- Rounding: gGain=48 loaded, G pixel 12'h003 -> (144+16)>>5 = 12'h005. B pixel 12'h000 -> 0.
- gain_upd with bGain=16 mid-frame -> that frame's B pixels are unchanged. After the next sof, B pixel 12'h400 -> 12'h200.
- Illegal tag 4'b0110 in frame, pixel 12'h123 -> Dout={12'h123,4'b0110}, err_cnt 0->1. eof while IDLE -> err_cnt 2. sof in ACTIVE -> err_cnt 3.
- rst_n low mid-frame for 1 cycle -> Dout=0, dout_en=0, in_frame=0 immediately. The next frame uses unity gains despite an earlier gain_upd.

Source files
------------

// File: rtl/awb_gain_apply_pkg.sv
// Shared ISP definitions for the white-balance gain stage: tag bit positions,
// widths, default gain format and the tag classifier.
package awb_gain_apply_pkg;

  localparam int PIXEL_W = 12;
  localparam int TAG_W   = 4;
  localparam int GAIN_W  = 8;
  localparam int PROD_W  = PIXEL_W + GAIN_W;

  // Colour tag bit positions on Din[3:0]
  localparam int TAG_R  = 2;
  localparam int TAG_B  = 1;
  localparam int TAG_GR = 0;
  localparam int TAG_GB = 3;

  localparam int GAIN_FRAC_DEF = 5;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(1 << GAIN_FRAC_DEF);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } awb_state_e;

  typedef enum logic [1:0] {
    CH_R   = 2'd0,
    CH_G   = 2'd1,
    CH_B   = 2'd2,
    CH_BAD = 2'd3
  } tag_ch_e;

  // Legal tags carry exactly one of R, B or the G group (GR and GB may both be set).
  function automatic tag_ch_e classify_tag(input logic [TAG_W-1:0] tag);
    logic r, g, b;
    r = tag[TAG_R];
    b = tag[TAG_B];
    g = tag[TAG_GR] | tag[TAG_GB];
    case ({r, g, b})
      3'b100:  classify_tag = CH_R;
      3'b010:  classify_tag = CH_G;
      3'b001:  classify_tag = CH_B;
      default: classify_tag = CH_BAD;
    endcase
  endfunction

endpackage

// File: rtl/awb_gain_apply_mul.sv
// Two-stage multiply / round / saturate pipe with tag and framing sidebands.
// Stage 1 registers pixel*gain; stage 2 rounds to nearest, clips and drives Dout.
module awb_mul_sat
  import awb_gain_apply_pkg::*;
#(
  parameter int                 GAIN_FRAC = GAIN_FRAC_DEF,
  parameter logic [PIXEL_W-1:0] PIX_MAX   = 12'hFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               sof_i,
  input  logic               eof_i,
  input  logic [PIXEL_W-1:0] pix_i,
  input  logic [TAG_W-1:0]   tag_i,
  input  logic [GAIN_W-1:0]  gain_i,
  output logic [15:0]        dout_o,
  output logic               dout_en_o,
  output logic               sof_o,
  output logic               eof_o
);

  localparam int RND_W = PROD_W + 1;

  logic [PROD_W-1:0]  prod_d, prod_q;
  logic [TAG_W-1:0]   tag1_q;
  logic               en1_q, sof1_q, eof1_q;
  logic [RND_W-1:0]   rounded;
  logic [PIXEL_W-1:0] sat_pix;
  logic [15:0]        dout_q;
  logic               en2_q, sof2_q, eof2_q;

  assign prod_d = PROD_W'(pix_i) * PROD_W'(gain_i);

  // Round half up in the fixed-point domain, then clip to the pixel ceiling.
  always_comb begin
    rounded = ({1'b0, prod_q} + RND_W'(1 << (GAIN_FRAC - 1))) >> GAIN_FRAC;
    sat_pix = (rounded > RND_W'(PIX_MAX)) ? PIX_MAX : rounded[PIXEL_W-1:0];
  end

  // Stage 1: product and sidebands; sidebands follow the inputs unconditionally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      tag1_q <= '0;
      en1_q  <= 1'b0;
      sof1_q <= 1'b0;
      eof1_q <= 1'b0;
    end else begin
      prod_q <= prod_d;
      tag1_q <= tag_i;
      en1_q  <= en_i;
      sof1_q <= sof_i;
      eof1_q <= eof_i;
    end
  end

  // Stage 2: Dout only moves on a qualified pixel, so it holds between pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      en2_q  <= 1'b0;
      sof2_q <= 1'b0;
      eof2_q <= 1'b0;
    end else begin
      if (en1_q) dout_q <= {sat_pix, tag1_q};
      en2_q  <= en1_q;
      sof2_q <= sof1_q;
      eof2_q <= eof1_q;
    end
  end

  assign dout_o    = dout_q;
  assign dout_en_o = en2_q;
  assign sof_o     = sof2_q;
  assign eof_o     = eof2_q;

endmodule

// File: rtl/awb_gain_apply.sv
// White-balance gain stage for the tagged Bayer stream. Gains are double
// buffered (pending -> shadow on sof) so a frame uses one consistent gain set.
// Stream handshake: data_en qualifies Din/sof/eof every cycle, there is no
// backpressure, and dout_en qualifies Dout/sof_o/eof_o two cycles later.
module awb_gain_apply
  import awb_gain_apply_pkg::*;
#(
  parameter int                 GAIN_FRAC = GAIN_FRAC_DEF,
  parameter logic [PIXEL_W-1:0] PIX_MAX   = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] Din,
  input  logic        data_en,
  input  logic        sof,
  input  logic        eof,
  input  logic [7:0]  rGain,
  input  logic [7:0]  gGain,
  input  logic [7:0]  bGain,
  input  logic        gain_upd,
  input  logic        bypass,
  output logic [15:0] Dout,
  output logic        dout_en,
  output logic        sof_o,
  output logic        eof_o,
  output logic        in_frame,
  output logic [15:0] err_cnt
);

  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1 << GAIN_FRAC);

  awb_state_e        state_q, state_d;
  logic              pend_q, pend_d;
  logic [GAIN_W-1:0] pend_r_q, pend_g_q, pend_b_q;
  logic [GAIN_W-1:0] pend_r_d, pend_g_d, pend_b_d;
  logic [GAIN_W-1:0] shd_r_q, shd_g_q, shd_b_q;
  logic [GAIN_W-1:0] shd_r_d, shd_g_d, shd_b_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [GAIN_W-1:0] gain_sel;
  logic              acc_sof, acc_eof, pix_in_frame;
  logic              err_tag, err_eof, err_restart;
  logic [1:0]        err_inc;
  tag_ch_e           ch;

  assign acc_sof      = data_en & sof;
  assign acc_eof      = data_en & eof;
  assign pix_in_frame = (state_q == ST_ACTIVE) | acc_sof;
  assign ch           = classify_tag(Din[TAG_W-1:0]);

  // FSM next state: eof always closes the frame (covers one-pixel frames), sof opens or restarts it.
  always_comb begin
    state_d = state_q;
    if (data_en) begin
      if (eof)      state_d = ST_IDLE;
      else if (sof) state_d = ST_ACTIVE;
    end
  end

  // Gain double-buffer, per-pixel gain select and error accounting.
  always_comb begin
    pend_d   = pend_q;
    pend_r_d = pend_r_q;
    pend_g_d = pend_g_q;
    pend_b_d = pend_b_q;
    shd_r_d  = shd_r_q;
    shd_g_d  = shd_g_q;
    shd_b_d  = shd_b_q;
    gain_sel = UNITY;
    err_tag  = 1'b0;

    // The reloaded shadow is used by the sof pixel itself, so select from shd_*_d.
    if (acc_sof && pend_q) begin
      shd_r_d = pend_r_q;
      shd_g_d = pend_g_q;
      shd_b_d = pend_b_q;
      pend_d  = 1'b0;
    end
    // A simultaneous update lands in pending only, after the old set moved.
    if (gain_upd) begin
      pend_r_d = rGain;
      pend_g_d = gGain;
      pend_b_d = bGain;
      pend_d   = 1'b1;
    end

    if (!bypass && pix_in_frame) begin
      case (ch)
        CH_R:    gain_sel = shd_r_d;
        CH_G:    gain_sel = shd_g_d;
        CH_B:    gain_sel = shd_b_d;
        default: begin
          gain_sel = UNITY;
          err_tag  = data_en;
        end
      endcase
    end

    err_eof     = acc_eof & ~sof & (state_q == ST_IDLE);
    err_restart = acc_sof & (state_q == ST_ACTIVE);
    err_inc     = {1'b0, err_tag} + {1'b0, err_eof} + {1'b0, err_restart};

    if (({1'b0, err_cnt_q} + 17'(err_inc)) > 17'h0FFFF) err_cnt_d = 16'hFFFF;
    else                                                 err_cnt_d = err_cnt_q + 16'(err_inc);
  end

  // Control state; reset restores unity shadow gains and drops any pending set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pend_q    <= 1'b0;
      pend_r_q  <= '0;
      pend_g_q  <= '0;
      pend_b_q  <= '0;
      shd_r_q   <= UNITY;
      shd_g_q   <= UNITY;
      shd_b_q   <= UNITY;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      pend_r_q  <= pend_r_d;
      pend_g_q  <= pend_g_d;
      pend_b_q  <= pend_b_d;
      shd_r_q   <= shd_r_d;
      shd_g_q   <= shd_g_d;
      shd_b_q   <= shd_b_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  awb_mul_sat #(
    .GAIN_FRAC (GAIN_FRAC),
    .PIX_MAX   (PIX_MAX)
  ) u_mul_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (data_en),
    .sof_i     (sof),
    .eof_i     (eof),
    .pix_i     (Din[15:4]),
    .tag_i     (Din[3:0]),
    .gain_i    (gain_sel),
    .dout_o    (Dout),
    .dout_en_o (dout_en),
    .sof_o     (sof_o),
    .eof_o     (eof_o)
  );

  assign in_frame = (state_q == ST_ACTIVE);
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_awb_gain_apply.sv
// Directed bench for awb_gain_apply: stimulus pushes expected {pixel,tag,sof,eof}
// and arrival cycle; a monitor pops and compares on every dout_en.
module tb_awb_gain_apply;

  localparam int W = 18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] Din = '0;
  logic        data_en = 1'b0;
  logic        sof = 1'b0;
  logic        eof = 1'b0;
  logic [7:0]  rGain = '0;
  logic [7:0]  gGain = '0;
  logic [7:0]  bGain = '0;
  logic        gain_upd = 1'b0;
  logic        bypass = 1'b0;
  logic [15:0] Dout;
  logic        dout_en;
  logic        sof_o;
  logic        eof_o;
  logic        in_frame;
  logic [15:0] err_cnt;

  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] mon_exp;
  int           mon_cyc;

  awb_gain_apply dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Din      (Din),
    .data_en  (data_en),
    .sof      (sof),
    .eof      (eof),
    .rGain    (rGain),
    .gGain    (gGain),
    .bGain    (bGain),
    .gain_upd (gain_upd),
    .bypass   (bypass),
    .Dout     (Dout),
    .dout_en  (dout_en),
    .sof_o    (sof_o),
    .eof_o    (eof_o),
    .in_frame (in_frame),
    .err_cnt  (err_cnt)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  // Driver: one qualified pixel, expected output pushed at issue time.
  task automatic send(input logic [11:0] pix, input logic [3:0] tag,
                      input logic s, input logic e, input logic [11:0] expv);
    Din     = {pix, tag};
    data_en = 1'b1;
    sof     = s;
    eof     = e;
    exp_q.push_back({expv, tag, s, e});
    cyc_q.push_back(cyc + 2);
    @(posedge clk); #1;
    data_en = 1'b0;
    sof     = 1'b0;
    eof     = 1'b0;
  endtask

  task automatic upd(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    rGain    = r;
    gGain    = g;
    bGain    = b;
    gain_upd = 1'b1;
    @(posedge clk); #1;
    gain_upd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    fork
      // Monitor: compare every qualified output against the scoreboard head.
      forever begin
        @(negedge clk);
        if (rst_n && dout_en) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output actual=%h required=none", Dout);
          end else begin
            mon_exp = exp_q.pop_front();
            mon_cyc = cyc_q.pop_front();
            check("dout_sof_eof", {14'd0, Dout, sof_o, eof_o}, {14'd0, mon_exp});
            check("latency", cyc, mon_cyc);
          end
        end
      end
    join_none

    // Reset state
    idle(3);
    check("rst_dout", Dout, 16'h0000);
    check("rst_dout_en", dout_en, 0);
    check("rst_sof_eof", {sof_o, eof_o}, 0);
    check("rst_in_frame", in_frame, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    idle(2);

    // Frame 1: unity gains, sof pixel passes unchanged
    send(12'h800, 4'b0100, 1, 0, 12'h800);
    check("f1_in_frame", in_frame, 1);
    send(12'h100, 4'b0001, 0, 1, 12'h100);
    check("f1_end_idle", in_frame, 0);
    idle(2);

    // Frame 2: rGain 2x saturates, G unity
    upd(8'd64, 8'd32, 8'd32);
    send(12'h900, 4'b0100, 1, 0, 12'hFFF);
    send(12'h100, 4'b1001, 0, 0, 12'h100);
    send(12'h400, 4'b0010, 0, 1, 12'h400);
    idle(1);

    // Frame 3: rounding, mid-frame update held pending, illegal tag
    upd(8'd32, 8'd48, 8'd32);
    send(12'h003, 4'b1000, 1, 0, 12'h005);
    send(12'h000, 4'b0010, 0, 0, 12'h000);
    upd(8'd32, 8'd48, 8'd16);
    send(12'h400, 4'b0010, 0, 0, 12'h400);
    send(12'h123, 4'b0110, 0, 0, 12'h123);
    check("err_illegal_tag", err_cnt, 1);
    send(12'h002, 4'b0001, 0, 1, 12'h003);

    // Out of frame: unity gain, stray eof counted
    send(12'h100, 4'b0100, 0, 1, 12'h100);
    check("err_eof_idle", err_cnt, 2);
    send(12'h7FF, 4'b1000, 0, 0, 12'h7FF);
    check("idle_in_frame", in_frame, 0);

    // Frame 4: new bGain on sof pixel, bypass, restart with same-cycle update
    send(12'h400, 4'b0010, 1, 0, 12'h200);
    send(12'h003, 4'b0001, 0, 0, 12'h005);
    bypass = 1'b1;
    send(12'h003, 4'b0001, 0, 0, 12'h003);
    bypass = 1'b0;
    rGain = 8'd96; gGain = 8'd48; bGain = 8'd16; gain_upd = 1'b1;
    send(12'h010, 4'b0100, 1, 0, 12'h010);
    gain_upd = 1'b0;
    check("err_restart", err_cnt, 3);
    check("restart_in_frame", in_frame, 1);
    send(12'h010, 4'b0100, 0, 0, 12'h010);
    send(12'h004, 4'b1000, 0, 1, 12'h006);

    // Frame 5: one-pixel frame picks up rGain=96
    send(12'h010, 4'b0100, 1, 1, 12'h030);
    check("one_pix_idle", in_frame, 0);
    check("err_after_f5", err_cnt, 3);
    idle(1);

    // Reset mid-frame with a pixel in flight and a pending update
    upd(8'd64, 8'd32, 8'd32);
    send(12'h100, 4'b0100, 1, 0, 12'h200);
    idle(3);
    upd(8'd128, 8'd32, 8'd32);
    send(12'h100, 4'b1000, 0, 0, 12'h100);
    rst_n = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    #1;
    check("midrst_dout", Dout, 16'h0000);
    check("midrst_dout_en", dout_en, 0);
    check("midrst_in_frame", in_frame, 0);
    check("midrst_err_cnt", err_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);
    check("flush_no_output", dout_en, 0);

    // Frame 6: unity gains after reset despite earlier update
    send(12'h100, 4'b0100, 1, 0, 12'h100);
    check("f6_in_frame", in_frame, 1);
    send(12'h100, 4'b1000, 0, 1, 12'h100);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
